// File: rtl/branch_unit.sv
// Multi-cycle relative-branch unit for the 6502-compatible core.
// Evaluates the branch condition, computes the target, and steps through
// the 2/3/4-cycle branch timing, including the dummy fetch on a page cross.
module branch_unit #(
  parameter int ADDR_W    = 16,
  parameter int PAGE_BITS = 8,
  parameter int N_IDX     = 7,
  parameter int V_IDX     = 6,
  parameter int Z_IDX     = 1,
  parameter int C_IDX     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        cond,
  input  logic [7:0]        offset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [7:0]        flags,
  output logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] dummy_addr,
  output logic              dummy_valid,
  output logic              done,
  output logic              taken,
  output logic              page_cross,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_we
);

  typedef enum logic [1:0] {IDLE, EVAL, ADD, FIX} state_t;

  state_t state, state_nx;

  // Operands latched at accept, results latched at the end of EVAL
  logic        [2:0]        cond_p0;
  logic signed [7:0]        offset_p0;
  logic        [ADDR_W-1:0] pc_p0;
  logic        [ADDR_W-1:0] target_p1;
  logic                     cross_p1;

  logic [ADDR_W-1:0] target_c;
  logic              cross_c;
  logic              take_c;

  logic              ready_nx, busy_nx, done_nx, taken_nx, page_cross_nx;
  logic              pc_we_nx, dummy_valid_nx;
  logic [ADDR_W-1:0] pc_out_nx, dummy_addr_nx;

  function automatic logic signed [ADDR_W-1:0] sext8(input logic signed [7:0] v);
    return {{(ADDR_W-8){v[7]}}, v};
  endfunction

  // cond[2:1]: 00=N, 01=V, 10=C, 11=Z
  function automatic logic flag_pick(input logic [7:0] f, input logic [1:0] s);
    logic [2:0] idx;
    case (s)
      2'b00:   idx = 3'(N_IDX);
      2'b01:   idx = 3'(V_IDX);
      2'b10:   idx = 3'(C_IDX);
      default: idx = 3'(Z_IDX);
    endcase
    return |(f & (8'b1 << idx));
  endfunction

  // Condition, target and page-cross evaluation (flags are live during EVAL)
  always_comb begin
    take_c   = (flag_pick(flags, cond_p0[2:1]) == cond_p0[0]);
    target_c = pc_p0 + sext8(offset_p0);
    cross_c  = (target_c[ADDR_W-1:PAGE_BITS] != pc_p0[ADDR_W-1:PAGE_BITS]);
  end

  // Next state and next registered outputs
  always_comb begin
    state_nx       = state;
    done_nx        = 1'b0;
    pc_we_nx       = 1'b0;
    page_cross_nx  = 1'b0;
    dummy_valid_nx = 1'b0;
    taken_nx       = taken;
    pc_out_nx      = pc_out;
    dummy_addr_nx  = dummy_addr;
    case (state)
      IDLE: begin
        if (start) state_nx = EVAL;
      end
      EVAL: begin
        if (!take_c) begin
          done_nx   = 1'b1;
          taken_nx  = 1'b0;
          pc_out_nx = pc_p0;
          state_nx  = IDLE;
        end else begin
          state_nx  = ADD;
        end
      end
      ADD: begin
        if (!cross_p1) begin
          done_nx   = 1'b1;
          taken_nx  = 1'b1;
          pc_we_nx  = 1'b1;
          pc_out_nx = target_p1;
          state_nx  = IDLE;
        end else begin
          dummy_valid_nx = 1'b1;
          dummy_addr_nx  = {pc_p0[ADDR_W-1:PAGE_BITS], target_p1[PAGE_BITS-1:0]};
          state_nx       = FIX;
        end
      end
      FIX: begin
        done_nx       = 1'b1;
        taken_nx      = 1'b1;
        pc_we_nx      = 1'b1;
        page_cross_nx = 1'b1;
        pc_out_nx     = target_p1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    ready_nx = (state_nx == IDLE);
    busy_nx  = !ready_nx;
  end

  // Stage p0: operand capture on accept; stage p1: EVAL results
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      cond_p0   <= cond;
      offset_p0 <= offset;
      pc_p0     <= pc_in;
    end
    if (state == EVAL) begin
      target_p1 <= target_c;
      cross_p1  <= cross_c;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      taken       <= 1'b0;
      page_cross  <= 1'b0;
      pc_we       <= 1'b0;
      dummy_valid <= 1'b0;
      pc_out      <= '0;
      dummy_addr  <= '0;
    end else begin
      state       <= state_nx;
      ready       <= ready_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      taken       <= taken_nx;
      page_cross  <= page_cross_nx;
      pc_we       <= pc_we_nx;
      dummy_valid <= dummy_valid_nx;
      pc_out      <= pc_out_nx;
      dummy_addr  <= dummy_addr_nx;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: 6502 branch timing, targets, page crosses.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  cond;
  logic [7:0]  offset;
  logic [15:0] pc_in;
  logic [7:0]  flags;
  logic        ready, busy, dummy_valid, done, taken, page_cross, pc_we;
  logic [15:0] dummy_addr, pc_out;

  int tests  = 0;
  int failed = 0;

  // Observations from the most recent issue
  int          lat;
  int          dum_n;
  logic [15:0] dum_addr;
  logic        o_taken, o_cross, o_we, o_ready;
  logic [15:0] o_pc;

  branch_unit #(.ADDR_W(16), .PAGE_BITS(8), .N_IDX(7), .V_IDX(6), .Z_IDX(1), .C_IDX(0)) dut (
    .clk(clk), .rst(rst), .start(start), .cond(cond), .offset(offset),
    .pc_in(pc_in), .flags(flags), .ready(ready), .busy(busy),
    .dummy_addr(dummy_addr), .dummy_valid(dummy_valid), .done(done),
    .taken(taken), .page_cross(page_cross), .pc_out(pc_out), .pc_we(pc_we)
  );

  always #5 clk = ~clk;

  // Drives one start (caller sits just after a rising edge), then follows
  // the branch until done, recording latency and the dummy-fetch cycle.
  task automatic issue(input logic [2:0] c, input logic [7:0] o,
                       input logic [15:0] p, input logic [7:0] f);
    int n;
    start = 1'b1; cond = c; offset = o; pc_in = p; flags = f;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; dum_n = 0; dum_addr = 16'h0000;
    while (done !== 1'b1 && n < 12) begin
      if (dummy_valid === 1'b1 && dum_n == 0) begin
        dum_n = n; dum_addr = dummy_addr;
      end
      @(posedge clk); #1;
      n++;
    end
    lat = (done === 1'b1) ? n : -1;
    o_taken = taken; o_cross = page_cross; o_we = pc_we; o_pc = pc_out; o_ready = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cond = 3'b000; offset = 8'h00; pc_in = 16'h0000; flags = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (ready !== 1'b1) begin failed++; $display("FAIL reset_ready got %b exp 1", ready); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (taken !== 1'b0) begin failed++; $display("FAIL reset_taken got %b exp 0", taken); end
    tests++; if (page_cross !== 1'b0) begin failed++; $display("FAIL reset_cross got %b exp 0", page_cross); end
    tests++; if (pc_we !== 1'b0) begin failed++; $display("FAIL reset_pc_we got %b exp 0", pc_we); end
    tests++; if (dummy_valid !== 1'b0) begin failed++; $display("FAIL reset_dummy_valid got %b exp 0", dummy_valid); end
    tests++; if (pc_out !== 16'h0000) begin failed++; $display("FAIL reset_pc_out got %h exp 0000", pc_out); end
    tests++; if (dummy_addr !== 16'h0000) begin failed++; $display("FAIL reset_dummy_addr got %h exp 0000", dummy_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_beq_taken();
    issue(3'b111, 8'h05, 16'h1002, 8'h02);
    tests++; if (lat !== 3) begin failed++; $display("FAIL beq_latency got %0d exp 3", lat); end
    tests++; if (o_taken !== 1'b1) begin failed++; $display("FAIL beq_taken got %b exp 1", o_taken); end
    tests++; if (o_pc !== 16'h1007) begin failed++; $display("FAIL beq_pc_out got %h exp 1007", o_pc); end
    tests++; if (o_cross !== 1'b0) begin failed++; $display("FAIL beq_cross got %b exp 0", o_cross); end
    tests++; if (o_we !== 1'b1) begin failed++; $display("FAIL beq_pc_we got %b exp 1", o_we); end
    tests++; if (o_ready !== 1'b1) begin failed++; $display("FAIL beq_ready_at_done got %b exp 1", o_ready); end
    tests++; if (dum_n !== 0) begin failed++; $display("FAIL beq_no_dummy got cycle %0d exp 0", dum_n); end
    @(posedge clk); #1;
    tests++; if (done !== 1'b0 || pc_we !== 1'b0) begin failed++; $display("FAIL beq_pulse_width got done=%b we=%b exp 0 0", done, pc_we); end
    tests++; if (taken !== 1'b1 || pc_out !== 16'h1007) begin failed++; $display("FAIL beq_hold got %b/%h exp 1/1007", taken, pc_out); end
  endtask

  task automatic test_bne_not_taken();
    issue(3'b110, 8'h05, 16'h1002, 8'h02);
    tests++; if (lat !== 2) begin failed++; $display("FAIL bne_latency got %0d exp 2", lat); end
    tests++; if (o_taken !== 1'b0) begin failed++; $display("FAIL bne_taken got %b exp 0", o_taken); end
    tests++; if (o_pc !== 16'h1002) begin failed++; $display("FAIL bne_pc_out got %h exp 1002", o_pc); end
    tests++; if (o_we !== 1'b0) begin failed++; $display("FAIL bne_pc_we got %b exp 0", o_we); end
    @(posedge clk); #1;
  endtask

  task automatic test_bcs_cross();
    issue(3'b101, 8'h20, 16'h10F0, 8'h01);
    tests++; if (dum_n !== 3) begin failed++; $display("FAIL bcs_dummy_cycle got %0d exp 3", dum_n); end
    tests++; if (dum_addr !== 16'h1010) begin failed++; $display("FAIL bcs_dummy_addr got %h exp 1010", dum_addr); end
    tests++; if (lat !== 4) begin failed++; $display("FAIL bcs_latency got %0d exp 4", lat); end
    tests++; if (o_pc !== 16'h1110) begin failed++; $display("FAIL bcs_pc_out got %h exp 1110", o_pc); end
    tests++; if (o_cross !== 1'b1) begin failed++; $display("FAIL bcs_cross got %b exp 1", o_cross); end
    tests++; if (o_we !== 1'b1 || o_taken !== 1'b1) begin failed++; $display("FAIL bcs_we_taken got %b/%b exp 1/1", o_we, o_taken); end
    @(posedge clk); #1;
    tests++; if (page_cross !== 1'b0 || dummy_valid !== 1'b0) begin failed++; $display("FAIL bcs_pulse_clear got cross=%b dv=%b exp 0 0", page_cross, dummy_valid); end
  endtask

  task automatic test_bmi_backward();
    issue(3'b001, 8'hF0, 16'h2005, 8'h80);
    tests++; if (lat !== 4) begin failed++; $display("FAIL bmi_latency got %0d exp 4", lat); end
    tests++; if (o_pc !== 16'h1FF5) begin failed++; $display("FAIL bmi_pc_out got %h exp 1ff5", o_pc); end
    tests++; if (o_cross !== 1'b1) begin failed++; $display("FAIL bmi_cross got %b exp 1", o_cross); end
    tests++; if (dum_addr !== 16'h20F5) begin failed++; $display("FAIL bmi_dummy_addr got %h exp 20f5", dum_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_bvc_wrap();
    issue(3'b010, 8'h20, 16'hFFF0, 8'h00);
    tests++; if (lat !== 4) begin failed++; $display("FAIL bvc_latency got %0d exp 4", lat); end
    tests++; if (o_pc !== 16'h0010) begin failed++; $display("FAIL bvc_pc_out got %h exp 0010", o_pc); end
    tests++; if (o_cross !== 1'b1) begin failed++; $display("FAIL bvc_cross got %b exp 1", o_cross); end
    tests++; if (dum_addr !== 16'hFF10) begin failed++; $display("FAIL bvc_dummy_addr got %h exp ff10", dum_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_offset();
    issue(3'b111, 8'h00, 16'h3456, 8'h02);
    tests++; if (lat !== 3) begin failed++; $display("FAIL zero_off_latency got %0d exp 3", lat); end
    tests++; if (o_pc !== 16'h3456 || o_cross !== 1'b0) begin failed++; $display("FAIL zero_off_result got %h/%b exp 3456/0", o_pc, o_cross); end
    @(posedge clk); #1;
  endtask

  task automatic test_not_taken_would_cross();
    issue(3'b100, 8'h20, 16'h10F0, 8'h01);
    tests++; if (lat !== 2) begin failed++; $display("FAIL bcc_latency got %0d exp 2", lat); end
    tests++; if (o_pc !== 16'h10F0 || o_cross !== 1'b0 || o_taken !== 1'b0) begin failed++; $display("FAIL bcc_result got %h/%b/%b exp 10f0/0/0", o_pc, o_cross, o_taken); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    issue(3'b110, 8'h10, 16'h4000, 8'h02);
    tests++; if (lat !== 2) begin failed++; $display("FAIL b2b_first_latency got %0d exp 2", lat); end
    issue(3'b111, 8'h10, 16'h4000, 8'h02);
    tests++; if (lat !== 3) begin failed++; $display("FAIL b2b_second_latency got %0d exp 3", lat); end
    tests++; if (o_pc !== 16'h4010) begin failed++; $display("FAIL b2b_second_pc got %h exp 4010", o_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_held();
    int dones;
    dones = 0;
    start = 1'b1; cond = 3'b101; offset = 8'h20; pc_in = 16'h10F0; flags = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
      if (k == 3) start = 1'b0;
    end
    tests++; if (dones !== 1) begin failed++; $display("FAIL held_start_dones got %0d exp 1", dones); end
    tests++; if (ready !== 1'b1) begin failed++; $display("FAIL held_start_idle got %b exp 1", ready); end
  endtask

  task automatic test_reset_in_fix();
    int dones;
    dones = 0;
    start = 1'b1; cond = 3'b101; offset = 8'h20; pc_in = 16'h10F0; flags = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (dummy_valid !== 1'b1) begin failed++; $display("FAIL rstfix_in_fix got %b exp 1", dummy_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++; if (ready !== 1'b1 || busy !== 1'b0) begin failed++; $display("FAIL rstfix_ready got %b/%b exp 1/0", ready, busy); end
    if (done === 1'b1) dones++;
    repeat (3) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
    tests++; if (dones !== 0) begin failed++; $display("FAIL rstfix_no_done got %0d exp 0", dones); end
    issue(3'b111, 8'h05, 16'h1002, 8'h02);
    tests++; if (lat !== 3 || o_pc !== 16'h1007) begin failed++; $display("FAIL rstfix_recover got %0d/%h exp 3/1007", lat, o_pc); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_bcs_cross();
    test_bmi_backward();
    test_bvc_wrap();
    test_zero_offset();
    test_not_taken_would_cross();
    test_back_to_back();
    test_start_held();
    test_reset_in_fix();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Multi-cycle relative-branch execution unit for the 6502-compatible core; successor to the single-cycle branch check.
- Accepts a decoded branch (condition code, signed 8-bit offset, next-instruction PC), evaluates the condition against the status register, and computes the target.
- Sequences the 6502 timing penalty: +1 cycle when taken, +1 more on page crossing, with the dummy-fetch address exposed.
- Sits between the prime decoder and the PC/fetch logic.

Parameters:
- ADDR_W, 16, PC/address width in bits (>= PAGE_BITS+1).
- PAGE_BITS, 8, low-address bits forming a page; a carry/borrow out of these is a page cross.
- N_IDX, 7, flag-register bit index of Negative.
- V_IDX, 6, flag-register bit index of Overflow.
- Z_IDX, 1, flag-register bit index of Zero.
- C_IDX, 0, flag-register bit index of Carry.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  branch request; accepted only when ready=1.
- cond  in  3  opcode bits [7:5]:
  - [2:1] selects the flag: 00=N, 01=V, 10=C, 11=Z.
  - [0] is the value that causes the branch to be taken.
- offset  in  8  signed two's-complement displacement.
- pc_in  in  ADDR_W  address of the instruction following the branch.
- flags  in  8  status register; sampled in EVAL, not at start.
- ready  out  1  high in IDLE.
- busy  out  1  high in any state other than IDLE.
- dummy_addr  out  ADDR_W  {pc_in high part, target low part}; valid when dummy_valid=1.
- dummy_valid  out  1  high during FIX only.
- done  out  1  one-cycle completion pulse.
- taken  out  1  condition result; valid when done=1.
- page_cross  out  1  valid when done=1; 0 if not taken.
- pc_out  out  ADDR_W  next PC: target if taken, else latched pc_in; valid when done=1.
- pc_we  out  1  equals done & taken.

Behaviour:
- Reset values: state=IDLE, ready=1, busy=0, done=0, taken=0, page_cross=0, pc_we=0, dummy_valid=0, pc_out=0, dummy_addr=0.
- Reset in any state aborts the operation; no done pulse is emitted.
- Accept: in IDLE with start=1, latch cond, offset and pc_in; next state is EVAL.
- start while busy is ignored and not queued.
- All outputs are registered.
- EVAL (1 cycle):
  - sel = flags[N/V/C/Z_IDX] per cond[2:1]; t = (sel == cond[0]).
  - Compute target = pc_in + sign_extend(offset), modulo 2^ADDR_W.
  - Compute cross = (target[ADDR_W-1:PAGE_BITS] != pc_in[ADDR_W-1:PAGE_BITS]).
  - If !t: done=1, taken=0, pc_out=pc_in, next state IDLE.
  - If t: next state ADD.
- ADD (1 cycle):
  - If !cross: done=1, taken=1, pc_we=1, pc_out=target, page_cross=0, next state IDLE.
  - If cross: next state FIX.
- FIX (1 cycle):
  - dummy_valid=1, dummy_addr={pc_in[ADDR_W-1:PAGE_BITS], target[PAGE_BITS-1:0]}.
  - Next cycle: done=1, taken=1, pc_we=1, page_cross=1, pc_out=target; return to IDLE.
- Latency from start edge to done:
  - 2 cycles if not taken.
  - 3 cycles if taken, same page.
  - 4 cycles if taken, page cross.
- These match 6502 branch timing of 2/3/4 cycles.
- ready rises in the same cycle as done, so back-to-back start in the done cycle is accepted.
- done, pc_we and page_cross are single-cycle pulses.
- taken and pc_out hold their values until the next done.
- Wrap-around: targets wrap modulo 2^ADDR_W. A wrap always changes the page bits, so it counts as a cross.
- offset=0x00, taken: target=pc_in, no cross, 3 cycles.

Test Plan:
- BEQ (cond=111), flags Z=1, pc_in=0x1002, offset=0x05 → done at start+3, taken=1, pc_out=0x1007, page_cross=0, pc_we pulses once.
- BNE (cond=110), Z=1, pc_in=0x1002 → done at start+2, taken=0, pc_out=0x1002, pc_we=0.
- BCS (cond=101), C=1, pc_in=0x10F0, offset=0x20:
  - dummy_valid with dummy_addr=0x1010 at start+3.
  - done at start+4, pc_out=0x1110, page_cross=1.
- BMI (cond=001), N=1, pc_in=0x2005, offset=0xF0 (-16) → pc_out=0x1FF5, page_cross=1, 4 cycles.
- BVC (cond=010), V=0, pc_in=0xFFF0, offset=0x20 → pc_out=0x0010, page_cross=1.
- Control cases:
  - start held high through busy → exactly one done per accepted start.
  - rst asserted in FIX → no done; ready=1 next cycle; new branch then completes normally.
